// File: rtl/shot_clock_core.sv
// Shot-clock countdown: BCD SS.cc value stepped by tick_toggle edges, run/pause/expire control.
// Optional buzzer pulse on expiry is built only when SHOT_BUZZER_EN is defined.
module shot_clock_core #(
  parameter int START_SEC  = 24,
  parameter int SHORT_SEC  = 14,
  parameter int BUZZ_TICKS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick_toggle,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_reload_full,
  input  logic       i_reload_short,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_cs_tens,
  output logic [3:0] o_cs_ones,
  output logic       o_running,
  output logic       o_expired,
  output logic       o_buzzer
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam logic [3:0] START_T = 4'(START_SEC / 10);
  localparam logic [3:0] START_O = 4'(START_SEC % 10);
  localparam logic [3:0] SHORT_T = 4'(SHORT_SEC / 10);
  localparam logic [3:0] SHORT_O = 4'(SHORT_SEC % 10);
  localparam logic [6:0] SHORT_V = 7'(SHORT_SEC);

  state_t     r_state;
  logic [3:0] r_st, r_so, r_ct, r_co;
  logic       r_running, r_expired, r_tick_prev;

  logic       w_tick_evt, w_cmd, w_below_short, w_last_step;
  logic       w_b0, w_b1, w_b2;
  logic [3:0] w_dec_st, w_dec_so, w_dec_ct, w_dec_co;
  logic [6:0] w_sec;

  assign w_tick_evt = i_tick_toggle ^ r_tick_prev;
  assign w_cmd      = i_reload_full | i_reload_short | i_start | i_pause;

  // Fractional part never matters: value < SHORT.00 exactly when whole seconds < SHORT.
  assign w_sec         = ({3'b000, r_st} * 7'd10) + {3'b000, r_so};
  assign w_below_short = (w_sec < SHORT_V);
  assign w_last_step   = (r_st == 4'd0) && (r_so == 4'd0) && (r_ct == 4'd0) && (r_co <= 4'd1);

  always_comb begin
    w_b0     = (r_co == 4'd0);
    w_b1     = w_b0 && (r_ct == 4'd0);
    w_b2     = w_b1 && (r_so == 4'd0);
    w_dec_co = w_b0 ? 4'd9 : r_co - 4'd1;
    w_dec_ct = w_b0 ? ((r_ct == 4'd0) ? 4'd9 : r_ct - 4'd1) : r_ct;
    w_dec_so = w_b1 ? ((r_so == 4'd0) ? 4'd9 : r_so - 4'd1) : r_so;
    w_dec_st = w_b2 ? r_st - 4'd1 : r_st;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_st        <= START_T;
      r_so        <= START_O;
      r_ct        <= 4'd0;
      r_co        <= 4'd0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
      r_tick_prev <= 1'b0;
    end else begin
      r_tick_prev <= i_tick_toggle;
      if (i_reload_full || i_reload_short) begin
        if (i_reload_full) begin
          r_st <= START_T;
          r_so <= START_O;
          r_ct <= 4'd0;
          r_co <= 4'd0;
        end else if (w_below_short) begin
          r_st <= SHORT_T;
          r_so <= SHORT_O;
          r_ct <= 4'd0;
          r_co <= 4'd0;
        end
        if (r_state == EXPIRED) begin
          r_state   <= IDLE;
          r_expired <= 1'b0;
        end
      end else if (i_start || i_pause) begin
        // Simultaneous start and pause cancel each other.
        if (i_start && !i_pause && (r_state == IDLE || r_state == PAUSE)) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end else if (i_pause && !i_start && r_state == RUN) begin
          r_state   <= PAUSE;
          r_running <= 1'b0;
        end
      end else if (w_tick_evt && r_state == RUN) begin
        if (w_last_step) begin
          r_st      <= 4'd0;
          r_so      <= 4'd0;
          r_ct      <= 4'd0;
          r_co      <= 4'd0;
          r_state   <= EXPIRED;
          r_running <= 1'b0;
          r_expired <= 1'b1;
        end else begin
          r_st <= w_dec_st;
          r_so <= w_dec_so;
          r_ct <= w_dec_ct;
          r_co <= w_dec_co;
        end
      end
    end
  end

`ifdef SHOT_BUZZER_EN
  localparam logic [9:0] BUZZ_LAST = 10'(BUZZ_TICKS - 1);

  logic       r_buzzer;
  logic [9:0] r_buzz_cnt;
  logic       w_tick_ok, w_expire_evt, w_buzz_clr;

  assign w_tick_ok    = w_tick_evt && !w_cmd;
  assign w_expire_evt = w_tick_ok && (r_state == RUN) && w_last_step;
  assign w_buzz_clr   = i_reload_full || (i_reload_short && w_below_short);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buzzer   <= 1'b0;
      r_buzz_cnt <= 10'd0;
    end else if (w_buzz_clr) begin
      r_buzzer   <= 1'b0;
      r_buzz_cnt <= 10'd0;
    end else if (w_expire_evt) begin
      r_buzzer   <= 1'b1;
      r_buzz_cnt <= 10'd0;
    end else if (r_buzzer && w_tick_ok) begin
      r_buzz_cnt <= r_buzz_cnt + 10'd1;
      if (r_buzz_cnt == BUZZ_LAST)
        r_buzzer <= 1'b0;
    end
  end

  assign o_buzzer = r_buzzer;
`else
  assign o_buzzer = 1'b0;
`endif

  assign o_sec_tens = r_st;
  assign o_sec_ones = r_so;
  assign o_cs_tens  = r_ct;
  assign o_cs_ones  = r_co;
  assign o_running  = r_running;
  assign o_expired  = r_expired;

endmodule

// File: doc/shot_clock_core.md
Name: shot_clock_core

Overview:
Shot-clock countdown engine. Consumes the 10 ms square-wave `tick_toggle` from the timer stage; every toggle edge (rising or falling) is one 10 ms step. Holds the remaining time as four BCD digits (SS.cc) and runs a run/pause/expire state machine. Feeds the display mux and the buzzer driver downstream.

Parameters:
START_SEC, 24, full reload value in whole seconds; legal range 1..99.
SHORT_SEC, 14, short reload value in whole seconds; legal range 1..START_SEC.
BUZZ_TICKS, 100, buzzer duration in 10 ms steps (only used under SHOT_BUZZER_EN); legal range 1..1023.

Ports:
clk  input  1  system clock, same domain as tick_toggle
reset  input  1  asynchronous, active-high reset
tick_toggle  input  1  toggles every 10 ms, synchronous to clk
start  input  1  one-cycle pulse: run
pause  input  1  one-cycle pulse: pause
reload_full  input  1  one-cycle pulse: load START_SEC.00
reload_short  input  1  one-cycle pulse: conditional load of SHORT_SEC.00
sec_tens  output  4  BCD tens-of-seconds
sec_ones  output  4  BCD seconds
cs_tens  output  4  BCD tenths
cs_ones  output  4  BCD hundredths
running  output  1  1 while in RUN
expired  output  1  1 while in EXPIRED
buzzer  output  1  buzzer enable

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: digits = START_SEC.00 (2,4,0,0 at default), state IDLE, running=0, expired=0, buzzer=0, tick_prev=0, buzz counter=0.
- Tick detect: tick_prev <= tick_toggle every cycle in all states. tick_evt = tick_toggle XOR tick_prev. One tick_evt per toggle edge, lasting exactly one cycle.
- States: IDLE, RUN, PAUSE, EXPIRED. running and expired are registered and decoded from the state.
- Command priority each cycle: reload_full > reload_short > start/pause > tick_evt. The lower-priority event in the same cycle is dropped.
- reload_full:
  - Digits <= START_SEC.00.
  - State is unchanged, except EXPIRED -> IDLE.
  - Clears buzzer and the buzz counter.
- reload_short:
  - If the current value is below SHORT_SEC.00, load SHORT_SEC.00. Otherwise digits are unchanged.
  - State rule is the same as reload_full. Buzzer is cleared only when the load occurs.
- start: IDLE/PAUSE -> RUN. Ignored in RUN and EXPIRED.
- pause: RUN -> PAUSE. Ignored otherwise.
- start and pause asserted together: both are ignored.
- Countdown (RUN only): on tick_evt, decrement the 4-digit BCD value by 0.01 at that clock edge; the new value is visible the next cycle.
  - Borrow chain cs_ones -> cs_tens -> sec_ones -> sec_tens.
  - A digit at 0 that borrows becomes 9.
  - Digits never leave 0..9.
- Expiry: a tick in RUN at 00.01 loads 00.00 and goes RUN -> EXPIRED on the same edge. expired=1 and running=0 the next cycle.
- 00.00 never wraps. Ticks in IDLE, PAUSE and EXPIRED do not change the digits.
- Reset mid-count: immediate return to the reset values.

Optional Feature:
SHOT_BUZZER_EN
- Defined:
  - On entry to EXPIRED, buzzer goes to 1 on the same edge that expired goes to 1.
  - A 10-bit counter then counts tick_evt.
  - buzzer drops to 0 on the edge of the BUZZ_TICKS-th tick after entry.
  - A reload that clears the buzzer clears it immediately.
- Undefined: buzzer is tied to 0, no counter logic is built, BUZZ_TICKS is unused.

Test Plan:
- Reset released, no commands -> digits 2,4,0,0; running=0; expired=0; buzzer=0. Toggle tick_toggle 50 times in IDLE -> digits still 24.00.
- start pulse, then 1 toggle -> 23.99. 100 more toggles -> 22.99. Check the 24.00->23.99 borrow across all four digits.
- At 22.99: pause, 30 toggles -> 22.99, running=0. start, 1 toggle -> 22.98. Assert start and pause in the same cycle -> state unchanged.
- Run from 24.00 with 2400 toggles -> 00.00; expired=1 on the cycle after the 2400th tick's edge; running=0. 10 further toggles -> 00.00. start -> ignored.
- reload_short while RUN at 20.00 -> stays 20.00, next tick 19.99. reload_short at 09.50 -> 14.00, still RUN. reload_full in the same cycle as a tick -> 24.00 with no decrement. reload_full in EXPIRED -> 24.00, IDLE, expired=0.
- SHOT_BUZZER_EN with BUZZ_TICKS=3: expire -> buzzer=1 with expired. After the 3rd subsequent toggle -> buzzer=0. Separately, reload_full during buzz -> buzzer=0 next cycle. Built without the macro -> buzzer always 0.
